ysyx_23060061_ifu: RTL and testbench
====================================

// Module: ysyx_23060061_ifu
// PURPOSE
//   Instruction fetch unit, directly upstream of the decoder. Holds the PC and
//   fetches one 32-bit instruction per step from instruction memory over a
//   valid/ready handshake. Presents the instruction (opcode/funct3 slices for the
//   decoder) with valid/ready, then waits for the next PC from execute/writeback.
//   Non-pipelined, one instruction in flight; sticky fault on bus error or misaligned PC.
// PARAMETERS
//   RESET_PC  32'h8000_0000  PC loaded on reset
// PORTS
//   clk          in   1   system clock, all state updates on posedge
//   rst          in   1   asynchronous, active-high reset
//   req_valid    out  1   fetch request valid
//   req_ready    in   1   imem accepts request
//   req_addr     out  32  fetch address (= pc)
//   resp_valid   in   1   imem response valid
//   resp_data    in   32  fetched instruction word
//   resp_err     in   1   imem access fault, qualified by resp_valid
//   inst_valid   out  1   inst/inst_pc valid to decode
//   inst_ready   in   1   decode consumes instruction
//   inst         out  32  instruction word
//   inst_pc      out  32  PC of inst
//   opcode       out  7   inst[6:0], to decoder
//   funct3       out  3   inst[14:12], to decoder
//   npc_valid    in   1   next PC valid from execute
//   npc          in   32  next PC
//   fault        out  1   sticky fault flag
//   fault_cause  out  2   00 none, 01 bus error, 10 misaligned npc
//   fetch_count  out  32  count of instructions accepted by decode
// BEHAVIOUR
//   Reset values: state=IDLE, pc=RESET_PC, inst=0, fault=0, fault_cause=00,
//     fetch_count=0; hence req_valid=0, inst_valid=0, req_addr=RESET_PC.
//   Reset assertion in any state (incl. mid-WAIT) returns to IDLE immediately;
//     an imem response still in flight at reset is dropped without error.
//   FSM (all outputs Moore-decoded from state, no combinational in->out paths):
//     IDLE : -> REQ on first clk edge after rst deasserts.
//     REQ  : req_valid=1, req_addr=pc. req_valid and req_addr held stable
//            until req_ready=1 -> WAIT.
//     WAIT : on resp_valid: resp_err=1 -> ERR with cause 01; else
//            inst<=resp_data, inst_pc<=pc, -> HOLD. resp_valid outside WAIT ignored.
//     HOLD : inst_valid=1; inst/inst_pc stable; on inst_ready=1 -> NPC,
//            fetch_count+1 (wraps 2^32-1 -> 0).
//     NPC  : on npc_valid: npc[1:0]!=0 -> ERR with cause 10, pc unchanged;
//            else pc<=npc, -> REQ. npc_valid outside NPC ignored.
//     ERR  : fault=1, no outputs valid, stays until rst.
//   Timing: zero-wait imem/decode/execute gives 4 cycles per instruction
//     (REQ, WAIT, HOLD, NPC); each stall extends only its own state.
//   opcode/funct3 are pure slices of registered inst, valid only with inst_valid.
//   PC arithmetic is done entirely upstream; IFU never increments pc itself.
//   npc = 0xFFFF_FFFC is legal (no wrap handling needed).
// TESTING
//   1. Reset release, req_ready=1 -> req_valid rises 1 cycle after release,
//      req_addr=0x8000_0000.
//   2. Zero-wait chain: resp 0x0010_0093 (addi), inst_ready=1, npc=0x8000_0004
//      -> opcode=7'b0010011, funct3=0, next req_addr=0x8000_0004,
//      4 cycles per instruction, fetch_count=1.
//   3. Stalls: req_ready low 3 cycles, inst_ready low 2 cycles
//      -> req_addr/inst held stable, one fetch only, fetch_count counts once.
//   4. npc=0x8000_0006 -> ERR, fault=1, cause=10, req_valid stays 0
//      until rst; a later npc_valid is ignored.
//   5. resp_valid with resp_err=1 -> fault=1, cause=01, inst_valid never asserts.
//   6. rst pulse in WAIT, then late resp_valid -> ignored, restart from
//      0x8000_0000, fetch_count=0.

Source files
------------

// File: rtl/ysyx_23060061_ifu.sv
// Instruction fetch unit: holds the PC, fetches one word from imem, hands it to decode, waits for next PC.
// Latency: 4 cycles per instruction with zero-wait neighbours (REQ, WAIT, HOLD, NPC); each stall stretches only its own state.
// Backpressure: req_valid/req_addr and inst_valid/inst held stable until the matching ready; one instruction in flight.
module ysyx_23060061_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    input  logic        resp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    input  logic        npc_valid,
    input  logic [31:0] npc,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fetch_count
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        NPC  = 3'd4,
        ERR  = 3'd5
    } ifuState_t;

    ifuState_t  state;
    ifuState_t  nextState;
    logic [31:0] pcReg;
    logic [31:0] instReg;
    logic [31:0] instPcReg;
    logic [1:0]  faultCauseReg;
    logic [31:0] fetchCountReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: nextState = REQ;
            REQ:  if (req_ready) nextState = WAIT;
            WAIT: if (resp_valid) nextState = resp_err ? ERR : HOLD;
            HOLD: if (inst_ready) nextState = NPC;
            NPC:  if (npc_valid) nextState = (npc[1:0] != 2'b00) ? ERR : REQ;
            ERR:  nextState = ERR;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        req_valid  = (state == REQ);
        inst_valid = (state == HOLD);
        fault      = (state == ERR);
    end

    // Datapath updates mirror the transitions above; pc is only ever loaded from npc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcReg         <= RESET_PC;
            instReg       <= 32'd0;
            instPcReg     <= 32'd0;
            faultCauseReg <= 2'b00;
            fetchCountReg <= 32'd0;
        end else begin
            case (state)
                WAIT: begin
                    if (resp_valid) begin
                        if (resp_err) begin
                            faultCauseReg <= 2'b01;
                        end else begin
                            instReg   <= resp_data;
                            instPcReg <= pcReg;
                        end
                    end
                end
                HOLD: begin
                    if (inst_ready) fetchCountReg <= fetchCountReg + 32'd1;
                end
                NPC: begin
                    if (npc_valid) begin
                        if (npc[1:0] != 2'b00) begin
                            faultCauseReg <= 2'b10;
                        end else begin
                            pcReg <= npc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_addr    = pcReg;
    assign inst        = instReg;
    assign inst_pc     = instPcReg;
    assign opcode      = instReg[6:0];
    assign funct3      = instReg[14:12];
    assign fault_cause = faultCauseReg;
    assign fetch_count = fetchCountReg;

endmodule

// File: tb/tb_ysyx_23060061_ifu.sv
// Randomized bench for ysyx_23060061_ifu: a transaction-level model tracks expected pc,
// fetched words and accepted-instruction count while stalls and stray handshakes are injected.
module tb_ysyx_23060061_ifu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = 32'd0;
    logic        resp_err = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        npc_valid = 1'b0;
    logic [31:0] npc = 32'd0;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] expPc;
    logic [31:0] expCount;
    logic [6:0]  lastOpcode;
    logic [2:0]  lastFunct3;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    ysyx_23060061_ifu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .opcode(opcode), .funct3(funct3),
        .npc_valid(npc_valid), .npc(npc),
        .fault(fault), .fault_cause(fault_cause), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Randomize every input except the one that currently drives the FSM (0 req,1 resp,2 inst,3 npc).
    task automatic noise(input int keep);
        if (keep != 0) req_ready = 1'($urandom_range(0, 1));
        if (keep != 1) begin
            resp_valid = 1'($urandom_range(0, 1));
            resp_data  = $urandom();
            resp_err   = 1'($urandom_range(0, 1));
        end
        if (keep != 2) inst_ready = 1'($urandom_range(0, 1));
        if (keep != 3) begin
            npc_valid = 1'($urandom_range(0, 1));
            npc       = $urandom();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_ready = 0; resp_valid = 0; resp_err = 0; inst_ready = 0; npc_valid = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        expPc    = RST_PC;
        expCount = 32'd0;
    endtask

    // One instruction from REQ back to REQ (or into ERR), with the given stall lengths.
    task automatic run_txn(input int reqSt, input int respSt, input int instSt, input int npcSt,
                           input logic [31:0] data, input logic err, input logic [31:0] nextPc);
        for (int i = 0; i < reqSt; i++) begin
            noise(0);
            req_ready = 1'b0;
            total++;
            if ({req_valid, inst_valid, fault, req_addr} !== {3'b100, expPc}) begin
                bad++;
                $display("FAIL req_stall got v=%b iv=%b f=%b addr=%h exp addr=%h", req_valid, inst_valid, fault, req_addr, expPc);
            end
            tick();
        end
        noise(0);
        req_ready = 1'b1;
        total++;
        if ({req_valid, req_addr} !== {1'b1, expPc}) begin
            bad++;
            $display("FAIL req got v=%b addr=%h exp v=1 addr=%h", req_valid, req_addr, expPc);
        end
        tick();
        for (int i = 0; i < respSt; i++) begin
            noise(1);
            resp_valid = 1'b0;
            total++;
            if ({req_valid, inst_valid, fault} !== 3'b000) begin
                bad++;
                $display("FAIL wait_stall got v=%b iv=%b f=%b exp 000", req_valid, inst_valid, fault);
            end
            tick();
        end
        noise(1);
        resp_valid = 1'b1;
        resp_data  = data;
        resp_err   = err;
        tick();
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        if (err) begin
            total++;
            if ({fault, fault_cause, inst_valid, req_valid} !== 5'b10100) begin
                bad++;
                $display("FAIL bus_err got f=%b cause=%b iv=%b v=%b exp f=1 cause=01", fault, fault_cause, inst_valid, req_valid);
            end
            return;
        end
        for (int i = 0; i <= instSt; i++) begin
            noise(2);
            inst_ready = (i == instSt);
            total++;
            if ({inst_valid, req_valid, inst, inst_pc, opcode, funct3, fetch_count} !==
                {2'b10, data, expPc, data[6:0], data[14:12], expCount}) begin
                bad++;
                $display("FAIL hold got iv=%b inst=%h pc=%h op=%b f3=%b cnt=%0d exp inst=%h pc=%h cnt=%0d",
                         inst_valid, inst, inst_pc, opcode, funct3, fetch_count, data, expPc, expCount);
            end
            lastOpcode = opcode;
            lastFunct3 = funct3;
            tick();
        end
        inst_ready = 1'b0;
        expCount = expCount + 32'd1;
        for (int i = 0; i <= npcSt; i++) begin
            noise(3);
            npc_valid = (i == npcSt);
            npc = (i == npcSt) ? nextPc : npc;
            total++;
            if ({inst_valid, req_valid, fault, fetch_count} !== {3'b000, expCount}) begin
                bad++;
                $display("FAIL npc_wait got iv=%b v=%b f=%b cnt=%0d exp cnt=%0d", inst_valid, req_valid, fault, fetch_count, expCount);
            end
            tick();
        end
        npc_valid = 1'b0;
        if (nextPc[1:0] != 2'b00) begin
            total++;
            if ({fault, fault_cause, req_valid, inst_valid} !== 5'b11000) begin
                bad++;
                $display("FAIL misaligned got f=%b cause=%b v=%b iv=%b exp f=1 cause=10", fault, fault_cause, req_valid, inst_valid);
            end
        end else begin
            expPc = nextPc;
            total++;
            if ({req_valid, req_addr, fault} !== {1'b1, expPc, 1'b0}) begin
                bad++;
                $display("FAIL next_req got v=%b addr=%h exp v=1 addr=%h", req_valid, req_addr, expPc);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_ready = 1'b1;
        tick();
        tick();
        total++;
        if ({req_valid, inst_valid, fault, fault_cause} !== 5'b00000) begin
            bad++;
            $display("FAIL reset_flags got v=%b iv=%b f=%b cause=%b exp all 0", req_valid, inst_valid, fault, fault_cause);
        end
        total++;
        if ({req_addr, fetch_count, inst} !== {RST_PC, 64'd0}) begin
            bad++;
            $display("FAIL reset_regs got addr=%h cnt=%0d inst=%h exp addr=%h cnt=0 inst=0", req_addr, fetch_count, inst, RST_PC);
        end
        rst = 1'b0;
        total++;
        if (req_valid !== 1'b0) begin
            bad++;
            $display("FAIL release_idle got v=%b exp 0", req_valid);
        end
        tick();
        total++;
        if ({req_valid, req_addr} !== {1'b1, RST_PC}) begin
            bad++;
            $display("FAIL first_req got v=%b addr=%h exp v=1 addr=%h", req_valid, req_addr, RST_PC);
        end
        expPc    = RST_PC;
        expCount = 32'd0;
    endtask

    task automatic test_zero_wait();
        run_txn(0, 0, 0, 0, 32'h0010_0093, 1'b0, 32'h8000_0004);
        total++;
        if ({lastOpcode, lastFunct3} !== {7'b0010011, 3'b000}) begin
            bad++;
            $display("FAIL addi_decode got op=%b f3=%b exp op=0010011 f3=000", lastOpcode, lastFunct3);
        end
        total++;
        if ({req_addr, fetch_count} !== {32'h8000_0004, 32'd1}) begin
            bad++;
            $display("FAIL zero_wait got addr=%h cnt=%0d exp addr=80000004 cnt=1", req_addr, fetch_count);
        end
    endtask

    task automatic test_stalls();
        logic [31:0] w;
        w = $urandom();
        run_txn(3, 0, 2, 0, w, 1'b0, expPc + 32'd4);
        total++;
        if (fetch_count !== 32'd2) begin
            bad++;
            $display("FAIL stall_count got %0d exp 2", fetch_count);
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic [31:0] r;
        for (int n = 0; n < 40; n++) begin
            w = $urandom();
            r = $urandom();
            r[1:0] = 2'b00;
            if (n == 20) r = 32'hFFFF_FFFC;
            run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), w, 1'b0, r);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] cnt;
        do_reset();
        run_txn(0, 1, 0, 1, 32'h0000_0013, 1'b0, 32'h8000_0004);
        cnt = expCount + 32'd1;
        run_txn(1, 0, 1, 0, 32'h0041_8193, 1'b0, 32'h8000_0006);
        for (int i = 0; i < 4; i++) begin
            noise(3);
            npc_valid = 1'b1;
            npc = 32'h8000_0010;
            tick();
            total++;
            if ({fault, fault_cause, req_valid, inst_valid, fetch_count} !== {5'b11000, cnt}) begin
                bad++;
                $display("FAIL err_sticky got f=%b cause=%b v=%b iv=%b cnt=%0d exp f=1 cause=10 cnt=%0d",
                         fault, fault_cause, req_valid, inst_valid, fetch_count, cnt);
            end
        end
        npc_valid = 1'b0;
    endtask

    task automatic test_bus_err();
        do_reset();
        run_txn(1, 2, 0, 0, 32'hDEAD_BEEF, 1'b1, 32'h8000_0004);
        for (int i = 0; i < 5; i++) begin
            noise(-1);
            tick();
            total++;
            if ({fault, fault_cause, inst_valid, req_valid, fetch_count} !== {5'b10100, 32'd0}) begin
                bad++;
                $display("FAIL bus_err_sticky got f=%b cause=%b iv=%b v=%b cnt=%0d exp f=1 cause=01 cnt=0",
                         fault, fault_cause, inst_valid, req_valid, fetch_count);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        run_txn(0, 0, 0, 0, 32'h0000_0013, 1'b0, 32'h8000_0040);
        run_txn(0, 0, 0, 0, 32'h0000_0033, 1'b0, 32'h8000_0080);
        noise(0);
        req_ready = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        total++;
        if ({req_valid, inst_valid, fault, req_addr, fetch_count} !== {3'b000, RST_PC, 32'd0}) begin
            bad++;
            $display("FAIL async_rst got v=%b iv=%b f=%b addr=%h cnt=%0d exp addr=%h cnt=0",
                     req_valid, inst_valid, fault, req_addr, fetch_count, RST_PC);
        end
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        total++;
        if ({req_valid, req_addr, fault, fault_cause, fetch_count} !== {1'b1, RST_PC, 3'b000, 32'd0}) begin
            bad++;
            $display("FAIL restart got v=%b addr=%h f=%b cause=%b cnt=%0d exp v=1 addr=%h",
                     req_valid, req_addr, fault, fault_cause, fetch_count, RST_PC);
        end
        expPc    = RST_PC;
        expCount = 32'd0;
        run_txn(0, 1, 0, 0, 32'h0020_0113, 1'b0, 32'h8000_0004);
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stalls();
        test_random();
        test_misaligned();
        test_bus_err();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
